// File: rtl/flop_clkgen_2ph.sv
// Two-phase non-overlapping clock generator for two-phase flop chains.
// A down-counter times each phase and gap; the outputs decode registered state only.
module flop_clkgen_2ph #(
    parameter int HI_CYC  = 4,
    parameter int GAP_CYC = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic ph1,
    output logic ph1b,
    output logic ph2,
    output logic ph2b,
    output logic cyc_start,
    output logic running
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_G1,
        S_P2,
        S_G2
    } state_t;

    localparam logic [CNT_W-1:0] HI_LD  = CNT_W'(HI_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(GAP_CYC - 1);

    if (HI_CYC < 1 || HI_CYC >= (1 << CNT_W) ||
        GAP_CYC < 1 || GAP_CYC >= (1 << CNT_W)) begin : g_param_err
        $error("flop_clkgen_2ph: HI_CYC/GAP_CYC out of range for CNT_W");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign w_done = (r_cnt == '0);

    // Each state is entered with its length minus one and leaves at zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            S_IDLE: begin
                if (en) begin
                    w_state_nxt = S_P1;
                    w_cnt_nxt   = HI_LD;
                end
            end
            S_P1: begin
                if (w_done) begin
                    w_state_nxt = S_G1;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_G1: begin
                if (w_done) begin
                    w_state_nxt = S_P2;
                    w_cnt_nxt   = HI_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_P2: begin
                if (w_done) begin
                    w_state_nxt = S_G2;
                    w_cnt_nxt   = GAP_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_G2: begin
                if (w_done) begin
                    w_state_nxt = en ? S_P1 : S_IDLE;
                    w_cnt_nxt   = en ? HI_LD : '0;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        ph1       = (r_state == S_P1);
        ph2       = (r_state == S_P2);
        ph1b      = ~ph1;
        ph2b      = ~ph2;
        cyc_start = (r_state == S_P1) && (r_cnt == HI_LD);
        running   = (r_state != S_IDLE);
    end

endmodule
